// File: rtl/fpu_pipe_pkg.sv
// rtl/fpu_pipe_pkg.sv - shared FPU pipeline widths and per-stage destination record
package fpu_pipe_pkg;

  localparam int FPU_REG_W = 5;
  localparam int FPU_DEPTH = 4;

  typedef struct packed {
    logic       valid;
    logic [4:0] rd;
    logic [1:0] lat;
  } fpu_dest_t;

endpackage

// File: rtl/fpu_dest_stage.sv
// rtl/fpu_dest_stage.sv - one destination-tracking stage register with hold/flush/load
module fpu_dest_stage
  import fpu_pipe_pkg::*;
(
  input  logic      clk,
  input  logic      rstn,
  input  logic      flush,
  input  logic      hold,
  input  fpu_dest_t d,
  output fpu_dest_t q
);

  // Flush only kills the valid bit; rd/lat are don't-care once invalid.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      q <= '0;
    end else if (flush) begin
      q.valid <= 1'b0;
    end else if (!hold) begin
      q <= d;
    end
  end

endmodule

// File: rtl/fpu_dest_tracker.sv
// rtl/fpu_dest_tracker.sv - FPU in-flight destination tracker, forwarding legality, RAW stall; FPU_HAZARD_CNT_EN adds hazard_cnt
module fpu_dest_tracker
  import fpu_pipe_pkg::*;
#(
  parameter int REG_W = FPU_REG_W,
  parameter int DEPTH = FPU_DEPTH
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             issue_valid,
  input  logic [REG_W-1:0] issue_rd,
  input  logic [1:0]       issue_lat,
  input  logic [REG_W-1:0] rsia,
  input  logic [REG_W-1:0] rsib,
  input  logic             stall_in,
  input  logic             flush,
  output logic             issue_ready,
  output logic             hazard,
  output logic [REG_W-1:0] rdi_buf_1,
  output logic [REG_W-1:0] rdi_buf_2,
  output logic [REG_W-1:0] rdi_buf_3,
  output logic [REG_W-1:0] rdi_buf_4,
  output logic             legal_1,
  output logic             legal_2,
  output logic             legal_3,
  output logic             legal_4,
  output logic             wb_valid,
  output logic [REG_W-1:0] wb_rd
`ifdef FPU_HAZARD_CNT_EN
  ,
  output logic [31:0]      hazard_cnt
`endif
);

  fpu_dest_t        st_q [DEPTH];
  fpu_dest_t        st_d [DEPTH];
  logic [DEPTH-1:0] ready;
  logic [DEPTH-1:0] legal;

  // Index 0 is stage 1 (youngest); each stage feeds the next older one.
  for (genvar k = 0; k < DEPTH; k++) begin : g_stage
    if (k == 0) begin : g_head
      assign st_d[k] = {issue_valid & ~hazard, issue_rd, issue_lat};
    end else begin : g_body
      assign st_d[k] = st_q[k-1];
    end
    fpu_dest_stage u_stage (
      .clk   (clk),
      .rstn  (rstn),
      .flush (flush),
      .hold  (stall_in),
      .d     (st_d[k]),
      .q     (st_q[k])
    );
  end

  // A result is ready at stage k once lat+1 <= k; only the youngest copy of an rd may forward.
  always_comb begin
    logic shadowed;
    ready = '0;
    legal = '0;
    for (int i = 0; i < DEPTH; i++) begin
      ready[i] = (st_q[i].lat <= 2'(i));
      shadowed = 1'b0;
      for (int j = 0; j < i; j++) begin
        if (st_q[j].valid && (st_q[j].rd == st_q[i].rd)) shadowed = 1'b1;
      end
      legal[i] = st_q[i].valid & ready[i] & ~shadowed;
    end
  end

  // Walk youngest to oldest; the first matching entry decides whether the source is pending.
  always_comb begin
    logic seen_a;
    logic seen_b;
    logic pend;
    seen_a = 1'b0;
    seen_b = 1'b0;
    pend   = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (st_q[i].valid && (st_q[i].rd == rsia) && !seen_a) begin
        seen_a = 1'b1;
        if (!ready[i]) pend = 1'b1;
      end
      if (st_q[i].valid && (st_q[i].rd == rsib) && !seen_b) begin
        seen_b = 1'b1;
        if (!ready[i]) pend = 1'b1;
      end
    end
    hazard = issue_valid & pend;
  end

  assign issue_ready = ~stall_in & ~hazard & ~flush;

  assign rdi_buf_1 = st_q[0].rd;
  assign rdi_buf_2 = st_q[1].rd;
  assign rdi_buf_3 = st_q[2].rd;
  assign rdi_buf_4 = st_q[3].rd;
  assign legal_1   = legal[0];
  assign legal_2   = legal[1];
  assign legal_3   = legal[2];
  assign legal_4   = legal[3];

  assign wb_valid = st_q[DEPTH-1].valid & ~stall_in & ~flush;
  assign wb_rd    = st_q[DEPTH-1].rd;

`ifdef FPU_HAZARD_CNT_EN
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      hazard_cnt <= '0;
    end else if (hazard && !stall_in && (hazard_cnt != '1)) begin
      hazard_cnt <= hazard_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: doc/fpu_dest_tracker.md
Name: fpu_dest_tracker

Overview:
- Tracks destination register and result readiness of every FPU op in flight through the fixed 4-stage FPU pipeline.
- Produces the per-stage destination indices and "legal to forward" flags consumed by the FPU forwarding control (rdi_buf_1..4, legal_1..4).
- Also produces the issue-side RAW hazard stall and the register-file writeback strobe.
- Sits between FPU issue/decode and the forwarding mux stage.

Parameters:
- REG_W, 5, FP register index width.
- DEPTH, 4, pipeline stages tracked. Fixed at 4 to match the forwarding control ports; other values unsupported.

Ports:
- clk  in  1  clock.
- rstn  in  1  reset, asynchronous, active-low.
- issue_valid  in  1  FPU op presented for issue this cycle.
- issue_rd  in  5  destination FP register of the presented op.
- issue_lat  in  2  result latency minus 1 (0..3 → ready at stage 1..4).
- rsia  in  5  source A of the presented op.
- rsib  in  5  source B of the presented op.
- stall_in  in  1  downstream freeze; holds all stages.
- flush  in  1  kill all in-flight ops.
- issue_ready  out  1  op accepted this cycle.
- hazard  out  1  RAW on an in-flight, not-yet-ready result.
- rdi_buf_1..rdi_buf_4  out  5 each  rd held in stage 1..4.
- legal_1..legal_4  out  1 each  stage k holds a forwardable result.
- wb_valid  out  1  stage-4 op retires to the register file this cycle.
- wb_rd  out  5  register written on wb_valid.

Behaviour:
- Each stage k (1..4) holds valid_k, rd_k and lat_k.
- Reset (rstn low, async) clears all valid_k, rd_k and lat_k to 0. Hence rdi_buf_k=0, legal_k=0, hazard=0, wb_valid=0, wb_rd=0. issue_ready=1 while stall_in=0.
- ready_k = (lat_k + 1 <= k).
- youngest_k(r) holds if valid_k and rd_k==r and no j<k has valid_j and rd_j==r.
- legal_k = valid_k & ready_k & youngest_k(rd_k). Older entries shadowed by a younger same-rd entry are never legal.
- rdi_buf_k = rd_k, combinational from registers.
- hazard = issue_valid & OR over k, over s∈{rsia,rsib}, of (youngest_k(s) & !ready_k). Purely combinational.
- issue_ready = !stall_in & !hazard & !flush.
- Rising edge, priority order:
  - flush: all valid_k←0. Takes priority over stall_in and issue; in-flight ops are dropped.
  - stall_in: every stage holds.
  - otherwise: stage k+1←stage k. Stage 1←{issue_valid & !hazard, issue_rd, issue_lat}, so a hazard inserts a bubble.
- wb_valid = valid_4 & !stall_in & !flush. wb_rd = rd_4. Retirement happens on the edge stage 4 shifts out.
- All ops occupy 4 stages regardless of latency; latency only affects forwarding eligibility.
- Latency from issue to wb_valid is 4 cycles absent stalls.
- Same rd issued back-to-back: both tracked; only the younger is forwardable; both retire in order.
- rsia==rsib: no special case.
- Hazard while stall_in=1: no bubble inserted (pipeline held). issue_ready=0.
- Reset asserted mid-operation discards everything immediately. No retirement occurs.

Optional Feature:
- Macro FPU_HAZARD_CNT_EN.
- When defined: adds output hazard_cnt [31:0]. Reset 0. Increments by 1 each cycle with issue_valid & hazard & !stall_in. Saturates at 0xFFFFFFFF. Cleared only by reset; unaffected by flush.
- When undefined: port and counter absent. All other behaviour identical.

Decomposition:
- Shared package fpu_pipe_pkg holds:
  - FPU_REG_W=5 and FPU_DEPTH=4.
  - typedef fpu_dest_t {valid, rd[4:0], lat[1:0]}.
- One sub-module, fpu_dest_stage: a single stage register with hold/flush/load, instantiated 4×.
- Shadow masking, hazard and ready logic stay in the top.

Test Plan:
- Reset: hold rstn=0 with issue_valid=1 → all legal_k=0, rdi_buf_k=0, wb_valid=0. After release, issue_ready=1.
- Forward timing: issue rd=3, lat=1. Following cycles: stage1 legal_1=0; stage2 legal_2=1, rdi_buf_2=3; stage4 wb_valid=1, wb_rd=3 four cycles after issue.
- Hazard bubble: issue rd=7, lat=3; next cycle present rsia=7.
  - hazard=1, issue_ready=0 for 3 cycles while rd=7 sits in stages 1–3, with bubbles inserted.
  - Op accepted the cycle rd=7 reaches stage 4 (legal_4=1).
- Shadowing: issue rd=5 lat=0, then rd=5 lat=0 → stage2 legal_2=0 while stage1 legal_1=1. Next issue with rsib=5, lat... → no hazard.
- Stall/flush: fill 4 stages, stall_in=1 for 3 cycles → outputs frozen, wb_valid=0. Then flush=1 with stall_in=1 → all valid cleared next edge, no wb_valid.
- FPU_HAZARD_CNT_EN defined: 5 hazard cycles, 2 of them with stall_in=1 → hazard_cnt=3.
